// File: rtl/spi_master_ctrl.sv
// SPI mode-0 initiator for single-byte ADI register transactions (16-bit instruction + 8 data bits).
// One request per frame; all pins and status outputs come straight from flops.
module spi_master_ctrl #(
    parameter int unsigned ADDR_SIZE = 13,
    parameter int unsigned DATA_SIZE = 8,
    parameter int unsigned CLK_DIV   = 4
) (
    input  logic                 I_clk,
    input  logic                 I_rst,
    input  logic                 I_start,
    input  logic                 I_rw,
    input  logic [ADDR_SIZE-1:0] I_addr,
    input  logic [DATA_SIZE-1:0] I_wdata,
    output logic [DATA_SIZE-1:0] O_rdata,
    output logic                 O_busy,
    output logic                 O_done,
    output logic                 O_sclk,
    output logic                 _O_csb,
    output logic                 O_sdo,
    input  logic                 I_sdi
);

    localparam int unsigned FrameW = 16 + DATA_SIZE;
    localparam int unsigned BitW   = $clog2(FrameW);
    localparam int unsigned CntW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StGap} state_e;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [BitW-1:0]        bit_q, bit_d;
    logic [FrameW-1:0]      tx_q, tx_d;
    logic [DATA_SIZE-1:0]   rx_q, rx_d;
    logic [DATA_SIZE-1:0]   rdata_q, rdata_d;
    logic                   rw_q, rw_d;
    logic                   sclk_q, sclk_d;
    logic                   csb_q, csb_d;
    logic                   sdo_q, sdo_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   cnt_last;
    logic [FrameW-1:0]      frame;

    assign cnt_last = (cnt_q == CntW'(CLK_DIV - 1));
    // Reads send zeros in the data slot; the address is zero-extended to 13 bits.
    assign frame = {I_rw, 2'b00, 13'(I_addr), (I_rw ? {DATA_SIZE{1'b0}} : I_wdata)};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        rdata_d = rdata_q;
        rw_d    = rw_q;
        sclk_d  = sclk_q;
        csb_d   = csb_q;
        sdo_d   = sdo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (I_start) begin
                    state_d = StSetup;
                    cnt_d   = '0;
                    tx_d    = frame;
                    rx_d    = '0;
                    rw_d    = I_rw;
                    sclk_d  = 1'b0;
                    csb_d   = 1'b0;
                    sdo_d   = frame[FrameW-1];
                    busy_d  = 1'b1;
                end
            end
            StSetup: begin
                if (cnt_last) begin
                    state_d = StShift;
                    cnt_d   = '0;
                    bit_d   = BitW'(FrameW - 1);
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StShift: begin
                if (cnt_last) begin
                    cnt_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                        // Only the data slot of a read carries slave data.
                        if (rw_q && (bit_q < BitW'(DATA_SIZE))) begin
                            rx_d = {rx_q[DATA_SIZE-2:0], I_sdi};
                        end
                    end else if (bit_q == '0) begin
                        state_d = StHold;
                        sclk_d  = 1'b0;
                        sdo_d   = 1'b0;
                    end else begin
                        sclk_d = 1'b0;
                        bit_d  = bit_q - BitW'(1);
                        tx_d   = {tx_q[FrameW-2:0], tx_q[FrameW-1]};
                        sdo_d  = tx_d[FrameW-1];
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StHold: begin
                if (cnt_last) begin
                    state_d = StGap;
                    cnt_d   = '0;
                    csb_d   = 1'b1;
                    sdo_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StGap: begin
                if (cnt_last) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    if (rw_q) begin
                        rdata_d = rx_q;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            rdata_q <= '0;
            rw_q    <= 1'b0;
            sclk_q  <= 1'b0;
            csb_q   <= 1'b1;
            sdo_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            rdata_q <= rdata_d;
            rw_q    <= rw_d;
            sclk_q  <= sclk_d;
            csb_q   <= csb_d;
            sdo_q   <= sdo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign O_rdata = rdata_q;
    assign O_busy  = busy_q;
    assign O_done  = done_q;
    assign O_sclk  = sclk_q;
    assign _O_csb  = csb_q;
    assign O_sdo   = sdo_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: two instances (13-bit addr / div 4, 8-bit addr / div 1) checked
// against a pin-level slave monitor and a frame-arithmetic reference model.
module tb_spi_master_ctrl;

    logic        clk = 1'b0;
    logic        rst   [2];
    logic        start [2];
    logic        rw    [2];
    logic [12:0] addr  [2];
    logic [7:0]  wdata [2];
    logic [7:0]  rdata [2];
    logic        busy  [2];
    logic        done  [2];
    logic        sclk  [2];
    logic        csb   [2];
    logic        sdo   [2];
    logic        sdi   [2];
    logic [7:0]  sbyte [2];

    int n_checks = 0;
    int n_errors = 0;

    // Slave monitor state
    logic [23:0] cap    [2];
    logic [23:0] flog   [2][8];
    int          frises [2][8];
    int          nframes [2];
    int          rises   [2];
    int          bad_rise [2];
    int          done_cnt [2];
    int          busy_run [2];
    int          idle_run [2];
    int          csb_run  [2];
    int          last_busy_len [2];
    int          last_idle_len [2];
    int          last_csb_gap  [2];
    logic        sclk_prev [2];
    logic        csb_prev  [2];
    logic        busy_prev [2];
    logic [7:0]  exp_rdata [2];

    always #5 clk = ~clk;

    spi_master_ctrl #(.ADDR_SIZE(13), .DATA_SIZE(8), .CLK_DIV(4)) u_dut0 (
        .I_clk(clk), .I_rst(rst[0]), .I_start(start[0]), .I_rw(rw[0]), .I_addr(addr[0]),
        .I_wdata(wdata[0]), .O_rdata(rdata[0]), .O_busy(busy[0]), .O_done(done[0]),
        .O_sclk(sclk[0]), ._O_csb(csb[0]), .O_sdo(sdo[0]), .I_sdi(sdi[0])
    );

    spi_master_ctrl #(.ADDR_SIZE(8), .DATA_SIZE(8), .CLK_DIV(1)) u_dut1 (
        .I_clk(clk), .I_rst(rst[1]), .I_start(start[1]), .I_rw(rw[1]), .I_addr(addr[1][7:0]),
        .I_wdata(wdata[1]), .O_rdata(rdata[1]), .O_busy(busy[1]), .O_done(done[1]),
        .O_sclk(sclk[1]), ._O_csb(csb[1]), .O_sdo(sdo[1]), .I_sdi(sdi[1])
    );

    function automatic int div_of(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    // Reference frame: R/W in bit 23, W1:W0 = 0, address in 20:8, write data (or 0) in 7:0.
    function automatic logic [23:0] exp_frame(input int k, input logic r, input logic [12:0] a,
                                              input logic [7:0] w);
        int unsigned am;
        int unsigned f;
        am = (k == 0) ? int'(a) : (int'(a) % 256);
        f  = (r ? 32'd8388608 : 32'd0) + am * 256 + (r ? 32'd0 : int'(w));
        return 24'(f);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Slave: captures SDO on every SCLK rise, drives SDI while SCLK is low.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (csb_prev[k] && !csb[k]) begin
                rises[k] = 0;
                cap[k] = '0;
                last_csb_gap[k] = csb_run[k];
            end
            if (csb[k]) csb_run[k]++; else csb_run[k] = 0;
            if (!sclk_prev[k] && sclk[k]) begin
                if (csb[k]) bad_rise[k]++;
                cap[k] = {cap[k][22:0], sdo[k]};
                rises[k]++;
            end
            if (!csb_prev[k] && csb[k]) begin
                flog[k][nframes[k] % 8] = cap[k];
                frises[k][nframes[k] % 8] = rises[k];
                nframes[k]++;
            end
            if (busy[k]) busy_run[k]++;
            else begin
                if (busy_prev[k]) last_busy_len[k] = busy_run[k];
                busy_run[k] = 0;
            end
            if (!busy[k]) idle_run[k]++;
            else begin
                if (!busy_prev[k]) last_idle_len[k] = idle_run[k];
                idle_run[k] = 0;
            end
            if (done[k] === 1'b1) done_cnt[k]++;
            if (!sclk[k]) sdi[k] = (rises[k] >= 16 && rises[k] < 24) ? sbyte[k][23 - rises[k]] : 1'b0;
            sclk_prev[k] = sclk[k];
            csb_prev[k]  = csb[k];
            busy_prev[k] = busy[k];
        end
    end

    // mode 0: start low, inputs scrambled; 1: start pulsed randomly while busy; 2: start untouched
    task automatic wait_done(input int k, input int mode, output bit got, output logic [7:0] rd);
        got = 1'b0;
        rd  = '0;
        for (int c = 0; c < 51 * div_of(k) + 20; c++) begin
            tick();
            if (done[k] === 1'b1) begin
                got = 1'b1;
                rd  = rdata[k];
                if (mode != 2) start[k] = 1'b0;
                break;
            end
            if (mode != 2) begin
                start[k] = (mode == 1) && busy[k] && $urandom_range(0, 1) == 1;
                rw[k]    = 1'($urandom);
                addr[k]  = 13'($urandom);
                wdata[k] = 8'($urandom);
            end
        end
    endtask

    task automatic finish_xfer(input int k, input int base, input int base_d, input logic [23:0] ef,
                               input bit got, input logic [7:0] rd, input logic r,
                               input logic [7:0] sb);
        check("done_seen", 32'(got), 1);
        check("rdata_at_done", 32'(rd), 32'(r ? sb : exp_rdata[k]));
        if (r) exp_rdata[k] = sb;
        check("frame_count", nframes[k] - base, 1);
        check("frame_bits", 32'(flog[k][base % 8]), 32'(ef));
        check("sclk_rises", frises[k][base % 8], 24);
        check("busy_cycles", last_busy_len[k], 51 * div_of(k));
        check("sclk_outside_csb", bad_rise[k], 0);
        tick();
        check("done_one_cycle", 32'(done[k]), 0);
        check("done_pulses", done_cnt[k] - base_d, 1);
        check("rdata_hold", 32'(rdata[k]), 32'(exp_rdata[k]));
    endtask

    task automatic run_xfer(input int k, input logic r, input logic [12:0] a, input logic [7:0] w,
                            input logic [7:0] sb, input int mode);
        int base, base_d;
        logic [23:0] ef;
        bit got;
        logic [7:0] rd;
        base   = nframes[k];
        base_d = done_cnt[k];
        ef     = exp_frame(k, r, a, w);
        tick();
        rw[k] = r; addr[k] = a; wdata[k] = w; sbyte[k] = sb; start[k] = 1'b1;
        tick();
        start[k] = 1'b0;
        check("busy_after_start", 32'(busy[k]), 1);
        check("csb_after_start", 32'(csb[k]), 0);
        wait_done(k, mode, got, rd);
        finish_xfer(k, base, base_d, ef, got, rd, r, sb);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base, base_d;
        bit got;
        logic [7:0] rd;
        logic [23:0] efa, efb;

        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; start[k] = 1'b0; rw[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
            sbyte[k] = '0; sdi[k] = 1'b0; nframes[k] = 0; rises[k] = 0; bad_rise[k] = 0;
            done_cnt[k] = 0; busy_run[k] = 0; idle_run[k] = 0; csb_run[k] = 0;
            last_busy_len[k] = 0; last_idle_len[k] = 0; last_csb_gap[k] = 0;
            sclk_prev[k] = 1'b0; csb_prev[k] = 1'b1; busy_prev[k] = 1'b0; cap[k] = '0;
            exp_rdata[k] = '0;
        end
        start[0] = 1'b1;  // reset must win over a simultaneous start
        repeat (3) tick();
        for (int k = 0; k < 2; k++) begin
            check("rst_sclk", 32'(sclk[k]), 0);
            check("rst_csb", 32'(csb[k]), 1);
            check("rst_sdo", 32'(sdo[k]), 0);
            check("rst_busy", 32'(busy[k]), 0);
            check("rst_done", 32'(done[k]), 0);
            check("rst_rdata", 32'(rdata[k]), 0);
        end
        start[0] = 1'b0;
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        tick();
        check("idle_no_start", 32'(busy[0]), 0);

        // Directed write and read on the 13-bit / div-4 instance
        run_xfer(0, 1'b0, 13'h0FF, 8'h01, 8'h3C, 0);
        run_xfer(0, 1'b1, 13'h001, 8'hEE, 8'hA5, 0);
        // Repeated start pulses mid-frame
        run_xfer(0, 1'b0, 13'($urandom), 8'($urandom), 8'($urandom), 1);

        // Reset in the middle of the shift phase
        tick();
        rw[0] = 1'b0; addr[0] = 13'h1234; wdata[0] = 8'h77; start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        for (int c = 0; c < 400 && rises[0] < 14; c++) tick();
        check("reached_bit10", rises[0], 14);
        base_d = done_cnt[0];
        rst[0] = 1'b1;
        tick();
        check("abort_csb", 32'(csb[0]), 1);
        check("abort_sclk", 32'(sclk[0]), 0);
        check("abort_busy", 32'(busy[0]), 0);
        check("abort_rdata", 32'(rdata[0]), 0);
        check("abort_done", 32'(done[0]), 0);
        rst[0] = 1'b0;
        exp_rdata[0] = '0;
        repeat (20) tick();
        check("abort_no_done", done_cnt[0] - base_d, 0);
        run_xfer(0, 1'b0, 13'h0A5, 8'hC3, 8'h11, 0);

        // Randomised traffic on instance 0
        for (int i = 0; i < 6; i++) begin
            run_xfer(0, 1'($urandom), 13'($urandom), 8'($urandom), 8'($urandom),
                     int'($urandom_range(0, 1)));
        end

        // 8-bit address / div-1 instance
        run_xfer(1, 1'b0, 13'h1FFF, 8'h5A, 8'h00, 0);
        check("addr8_frame", 32'(flog[1][(nframes[1] - 1) % 8]), 32'h00FF5A);

        // Back-to-back with start held high
        base   = nframes[1];
        base_d = done_cnt[1];
        efa = exp_frame(1, 1'b0, 13'h012, 8'h9C);
        efb = exp_frame(1, 1'b0, 13'h0E1, 8'h36);
        tick();
        rw[1] = 1'b0; addr[1] = 13'h012; wdata[1] = 8'h9C; start[1] = 1'b1;
        tick();
        addr[1] = 13'h0E1; wdata[1] = 8'h36;
        check("b2b_busy_a", 32'(busy[1]), 1);
        wait_done(1, 2, got, rd);
        check("b2b_done_a", 32'(got), 1);
        check("b2b_frame_a", 32'(flog[1][base % 8]), 32'(efa));
        tick();
        start[1] = 1'b0;
        check("b2b_busy_b", 32'(busy[1]), 1);
        check("b2b_idle_gap", last_idle_len[1], 1);
        wait_done(1, 0, got, rd);
        check("b2b_done_b", 32'(got), 1);
        check("b2b_frame_b", 32'(flog[1][(base + 1) % 8]), 32'(efb));
        check("b2b_rises_b", frises[1][(base + 1) % 8], 24);
        check("b2b_csb_gap", last_csb_gap[1], 2);
        check("b2b_busy_len", last_busy_len[1], 51);
        check("b2b_rdata", 32'(rd), 32'(exp_rdata[1]));
        tick();
        check("b2b_done_pulses", done_cnt[1] - base_d, 2);

        for (int i = 0; i < 6; i++) begin
            run_xfer(1, 1'($urandom), 13'($urandom), 8'($urandom), 8'($urandom),
                     int'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
